// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; `ALU_ARB_OPCHECK_EN adds opcode range checking (ERR).
// Latency: grant at edge N, ACK high from N+SETTLE_CYCLES to N+SETTLE_CYCLES+1; one op per SETTLE_CYCLES+2 cycles.
// Backpressure: REQ sampled only in IDLE; a losing requester holds REQ and wins the following arbitration.
module alu_req_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPRN_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 1     // legal range 1..15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [OPRN_WIDTH-1:0] OPRN0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    output logic                  ACK0,
    input  logic                  REQ1,
    input  logic [OPRN_WIDTH-1:0] OPRN1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RES,
    output logic                  ZFLAG,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO
`ifdef ALU_ARB_OPCHECK_EN
    ,
    output logic                  ERR
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              settle_cnt;
    logic                    last_gnt;
    logic                    any_req;
    logic                    win;
    logic                    op_bad;
    logic [OPRN_WIDTH-1:0]   win_oprn;
    logic [DATA_WIDTH-1:0]   win_op1;
    logic [DATA_WIDTH-1:0]   win_op2;

    // With both requesting, the one that did not win last time goes next.
    assign any_req  = REQ0 | REQ1;
    assign win      = (REQ0 & REQ1) ? ~last_gnt : REQ1;
    assign win_oprn = win ? OPRN1 : OPRN0;
    assign win_op1  = win ? OP1_1 : OP1_0;
    assign win_op2  = win ? OP2_1 : OP2_0;

`ifdef ALU_ARB_OPCHECK_EN
    assign op_bad = (win_oprn == '0) || (win_oprn > OPRN_WIDTH'(9));
`else
    assign op_bad = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ACK0      = 1'b0;
        ACK1      = 1'b0;
        BUSY      = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (any_req) begin
                    state_nxt = op_bad ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt == SETTLE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ACK0      = ~last_gnt;
                ACK1      = last_gnt;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            settle_cnt <= '0;
            last_gnt   <= 1'b1;
            ALU_OP1    <= '0;
            ALU_OP2    <= '0;
            ALU_OPRN   <= '0;
            RES        <= '0;
            ZFLAG      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_gnt <= win;
                        if (op_bad) begin
                            RES   <= '0;
                            ZFLAG <= 1'b0;
                        end else begin
                            ALU_OP1    <= win_op1;
                            ALU_OP2    <= win_op2;
                            ALU_OPRN   <= win_oprn;
                            settle_cnt <= 4'd1;
                        end
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable SETTLE_CYCLES cycles by this edge.
                    if (settle_cnt == SETTLE) begin
                        RES        <= ALU_OUT;
                        ZFLAG      <= ALU_ZERO;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERR <= 1'b0;
        end else if (state == IDLE && any_req) begin
            ERR <= op_bad;
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (SETTLE_CYCLES 1 and 4), a per-cycle transaction model and directed vectors.
module tb_alu_req_arbiter;

    localparam int DW = 32;
    localparam int OW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req0 [2];
    logic          req1 [2];
    logic          ack0 [2];
    logic          ack1 [2];
    logic          busy [2];
    logic          zflag [2];
    logic          alu_zero [2];
    logic [DW-1:0] op1_0 [2];
    logic [DW-1:0] op2_0 [2];
    logic [DW-1:0] op1_1 [2];
    logic [DW-1:0] op2_1 [2];
    logic [DW-1:0] res [2];
    logic [DW-1:0] alu_op1 [2];
    logic [DW-1:0] alu_op2 [2];
    logic [DW-1:0] alu_out [2];
    logic [OW-1:0] oprn0 [2];
    logic [OW-1:0] oprn1 [2];
    logic [OW-1:0] alu_oprn [2];
`ifdef ALU_ARB_OPCHECK_EN
    logic          err [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int sc(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Reference ALU: 1 add, 2 sub, 3 mul, 4 srl, 5 sll, 6 and, 7 or, 8 nor, 9 slt.
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a * b;
            6'd4:    return a >> b[4:0];
            6'd5:    return a << b[4:0];
            6'd6:    return a & b;
            6'd7:    return a | b;
            6'd8:    return ~(a | b);
            6'd9:    return {31'd0, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            alu_req_arbiter #(
                .DATA_WIDTH   (DW),
                .OPRN_WIDTH   (OW),
                .SETTLE_CYCLES(g == 0 ? 1 : 4)
            ) u_dut (
                .CLK     (clk),
                .RST     (rst),
                .REQ0    (req0[g]),
                .OPRN0   (oprn0[g]),
                .OP1_0   (op1_0[g]),
                .OP2_0   (op2_0[g]),
                .ACK0    (ack0[g]),
                .REQ1    (req1[g]),
                .OPRN1   (oprn1[g]),
                .OP1_1   (op1_1[g]),
                .OP2_1   (op2_1[g]),
                .ACK1    (ack1[g]),
                .RES     (res[g]),
                .ZFLAG   (zflag[g]),
                .BUSY    (busy[g]),
                .ALU_OP1 (alu_op1[g]),
                .ALU_OP2 (alu_op2[g]),
                .ALU_OPRN(alu_oprn[g]),
                .ALU_OUT (alu_out[g]),
                .ALU_ZERO(alu_zero[g])
`ifdef ALU_ARB_OPCHECK_EN
                ,
                .ERR     (err[g])
`endif
            );
            assign alu_out[g]  = alu_fn(alu_op1[g], alu_op2[g], alu_oprn[g]);
            assign alu_zero[g] = (alu_out[g] == '0);
        end
    endgenerate

    task automatic check(input string nm, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Model: t = cycles since grant (-1 when idle); ACK while t == SETTLE; idle again at SETTLE+1.
    int            m_t   [2];
    logic          m_lg  [2];
    logic [DW-1:0] m_op1 [2];
    logic [DW-1:0] m_op2 [2];
    logic [OW-1:0] m_opr [2];
    logic [DW-1:0] m_res [2];
    logic          m_z   [2];
    logic          m_err [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_t[i] = -1; m_lg[i] = 1'b1; m_op1[i] = '0; m_op2[i] = '0; m_opr[i] = '0;
            m_res[i] = '0; m_z[i] = 1'b0; m_err[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    m_t[i] = -1; m_lg[i] = 1'b1; m_op1[i] = '0; m_op2[i] = '0; m_opr[i] = '0;
                    m_res[i] = '0; m_z[i] = 1'b0; m_err[i] = 1'b0;
                end else if (m_t[i] < 0) begin
                    if (req0[i] || req1[i]) begin
                        logic          w;
                        logic [OW-1:0] o;
                        w = (req0[i] && req1[i]) ? !m_lg[i] : req1[i];
                        m_lg[i] = w;
                        o = w ? oprn1[i] : oprn0[i];
`ifdef ALU_ARB_OPCHECK_EN
                        if (o < 1 || o > 9) begin
                            m_t[i] = sc(i); m_res[i] = '0; m_z[i] = 1'b0; m_err[i] = 1'b1;
                        end else
`endif
                        begin
                            m_err[i] = 1'b0;
                            m_t[i]   = 0;
                            m_opr[i] = o;
                            m_op1[i] = w ? op1_1[i] : op1_0[i];
                            m_op2[i] = w ? op2_1[i] : op2_0[i];
                        end
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == sc(i)) begin
                        m_res[i] = alu_fn(m_op1[i], m_op2[i], m_opr[i]);
                        m_z[i]   = (m_res[i] == '0);
                    end else if (m_t[i] > sc(i)) begin
                        m_t[i] = -1;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                check("ack0", i, ack0[i], (m_t[i] == sc(i)) && !m_lg[i]);
                check("ack1", i, ack1[i], (m_t[i] == sc(i)) && m_lg[i]);
                check("busy", i, busy[i], m_t[i] >= 0);
                check("res", i, res[i], m_res[i]);
                check("zflag", i, zflag[i], m_z[i]);
                check("alu_op1", i, alu_op1[i], m_op1[i]);
                check("alu_op2", i, alu_op2[i], m_op2[i]);
                check("alu_oprn", i, alu_oprn[i], m_opr[i]);
`ifdef ALU_ARB_OPCHECK_EN
                check("err", i, err[i], m_err[i]);
`endif
            end
        end
    end

    task automatic drive(input int i, input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
        if (r == 0) begin
            op1_0[i] = a; op2_0[i] = b; oprn0[i] = op; req0[i] = 1'b1;
        end else begin
            op1_1[i] = a; op2_1[i] = b; oprn1[i] = op; req1[i] = 1'b1;
        end
    endtask

    // Issue one op, wait (bounded) for its ACK, check latency and captured result.
    task automatic run_op(input int i, input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OW-1:0] op, input logic [DW-1:0] er, input logic ez, input string nm);
        int   k;
        logic got;
        @(negedge clk);
        drive(i, r, a, b, op);
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) check({nm, "_oprn_after_grant"}, i, alu_oprn[i], op);
            got = (r == 0) ? ack0[i] : ack1[i];
            if (got) check({nm, "_other_ack"}, i, (r == 0) ? ack1[i] : ack0[i], 1'b0);
        end
        check({nm, "_ack_latency"}, i, k, sc(i) + 1);
        check({nm, "_res"}, i, res[i], er);
        check({nm, "_zflag"}, i, zflag[i], ez);
`ifdef ALU_ARB_OPCHECK_EN
        check({nm, "_err"}, i, err[i], 1'b0);
`endif
        @(negedge clk);
        req0[i] = 1'b0; req1[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k;
        int            nb;
        int            seq[$];
        logic [DW-1:0] rs[$];
        logic [DW-1:0] exp_res[4];

        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; req1[i] = 1'b0; oprn0[i] = '0; oprn1[i] = '0;
            op1_0[i] = '0; op2_0[i] = '0; op1_1[i] = '0; op2_1[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", 0, busy[0], 1'b0);
        check("rst_ack0", 0, ack0[0], 1'b0);
        check("rst_res", 0, res[0], 32'd0);
        check("rst_alu_oprn", 1, alu_oprn[1], 6'd0);
        rst = 1'b1;

        run_op(0, 0, 32'd15, 32'd3, 6'h01, 32'd18, 1'b0, "add");
        run_op(0, 1, 32'd11, 32'd11, 6'h09, 32'd0, 1'b1, "slt");

        // Both held: grants must alternate 0,1,0,1 starting with 0.
        @(negedge clk);
        drive(0, 0, 32'd7, 32'd5, 6'h03);
        drive(0, 1, 32'd15, 32'd5, 6'h02);
        for (int c = 0; c < 60 && seq.size() < 4; c++) begin
            @(posedge clk); #1;
            if (ack0[0]) begin seq.push_back(0); rs.push_back(res[0]); end
            if (ack1[0]) begin seq.push_back(1); rs.push_back(res[0]); end
        end
        @(negedge clk);
        req0[0] = 1'b0; req1[0] = 1'b0;
        check("rr_count", 0, seq.size(), 4);
        exp_res = '{32'd35, 32'd10, 32'd35, 32'd10};
        for (int j = 0; j < seq.size() && j < 4; j++) begin
            check("rr_order", 0, seq[j], j % 2);
            check("rr_res", 0, rs[j], exp_res[j]);
        end
        repeat (2) @(negedge clk);

`ifdef ALU_ARB_OPCHECK_EN
        drive(0, 0, 32'd1, 32'd2, 6'h0F);
        k = 0;
        while (!ack0[0] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("badop_ack_latency", 0, k, 1);
        check("badop_err", 0, err[0], 1'b1);
        check("badop_res", 0, res[0], 32'd0);
        check("badop_alu_oprn_kept", 0, alu_oprn[0], 6'h02);
        check("badop_alu_op1_kept", 0, alu_op1[0], 32'd15);
        @(negedge clk);
        req0[0] = 1'b0;
        run_op(0, 0, 32'd6, 32'd3, 6'h06, 32'd2, 1'b0, "after_badop");
`endif

        // SETTLE_CYCLES=4: operands stable for the whole op, BUSY for 5 cycles.
        @(negedge clk);
        drive(1, 0, 32'hFFFF_FFFF, 32'd2, 6'h04);
        k = 0; nb = 0;
        while (!ack0[1] && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (busy[1]) nb++;
            check("s4_alu_op1_stable", 1, alu_op1[1], 32'hFFFF_FFFF);
            check("s4_alu_oprn_stable", 1, alu_oprn[1], 6'h04);
            if (k == 1) op1_0[1] = 32'd0;
        end
        check("s4_ack_latency", 1, k, 5);
        check("s4_res", 1, res[1], 32'h3FFF_FFFF);
        @(negedge clk);
        req0[1] = 1'b0;
        @(posedge clk); #1;
        check("s4_busy_after", 1, busy[1], 1'b0);
        check("s4_busy_cycles", 1, nb, 5);

        // Reset during EXEC drops the op.
        @(negedge clk);
        drive(1, 0, 32'd100, 32'd23, 6'h01);
        @(posedge clk);
        @(negedge clk);
        check("exec_busy", 1, busy[1], 1'b1);
        rst = 1'b0;
        req0[1] = 1'b0;
        #1;
        check("rst_exec_busy", 1, busy[1], 1'b0);
        check("rst_exec_ack0", 1, ack0[1], 1'b0);
        check("rst_exec_res", 1, res[1], 32'd0);
        check("rst_exec_alu_op1", 1, alu_op1[1], 32'd0);
        check("rst_exec_alu_oprn", 1, alu_oprn[1], 6'd0);
        @(negedge clk);
        rst = 1'b1;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ack0[1] || ack1[1]) nb++;
        end
        check("no_ack_after_rst", 1, nb, 0);
        run_op(1, 0, 32'd100, 32'd23, 6'h01, 32'd123, 1'b0, "rerun");
        run_op(0, 1, 32'd5, 32'd9, 6'h09, 32'd1, 1'b0, "slt_true");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single combinational ALU (OP1/OP2/OPRN in, OUT/ZERO out) between two requesters, e.g. the instruction datapath and the address-calculation unit.
- Arbitrates round-robin, registers the winning operands onto the ALU inputs, and waits a programmable settle time.
- Captures OUT/ZERO and returns them to the granted requester with a one-cycle ACK pulse.

Parameters:
- DATA_WIDTH, 32, operand/result width; matches `DATA_WIDTH.
- OPRN_WIDTH, 6, opcode width; matches `ALU_OPRN_WIDTH.
- SETTLE_CYCLES, 1, cycles ALU inputs are held stable before capture; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ0  input  1  requester 0 request.
- OPRN0  input  OPRN_WIDTH  requester 0 opcode.
- OP1_0  input  DATA_WIDTH  requester 0 operand 1.
- OP2_0  input  DATA_WIDTH  requester 0 operand 2.
- ACK0  output  1  requester 0 completion pulse.
- REQ1, OPRN1, OP1_1, OP2_1, ACK1: same as above, for requester 1.
- RES  output  DATA_WIDTH  captured ALU result.
- ZFLAG  output  1  captured ALU ZERO.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- ALU_OP1  output  DATA_WIDTH  registered ALU operand 1.
- ALU_OP2  output  DATA_WIDTH  registered ALU operand 2.
- ALU_OPRN  output  OPRN_WIDTH  registered ALU opcode.
- ALU_OUT  input  DATA_WIDTH  ALU result.
- ALU_ZERO  input  1  ALU zero flag.

Behaviour:
- Reset (RST=0, immediate, asynchronous):
  - FSM goes to IDLE.
  - ACK0, ACK1, BUSY, ZFLAG = 0; RES = 0.
  - ALU_OP1, ALU_OP2, ALU_OPRN = 0.
  - Settle counter = 0; LAST_GNT = 1, so requester 0 wins the first tie.
- States:
  - IDLE -> EXEC when REQ0 or REQ1 is sampled high.
  - EXEC -> RESP when the settle counter reaches SETTLE_CYCLES.
  - RESP -> IDLE unconditionally.
- Arbitration, at the IDLE edge:
  - Single request: that requester is granted.
  - Both requesting: the requester other than LAST_GNT is granted.
  - LAST_GNT is updated to the winner on the same edge.
  - The winner's OP1/OP2/OPRN are registered into ALU_OP1/ALU_OP2/ALU_OPRN on the same edge.
- EXEC:
  - ALU_* are held constant.
  - The counter increments from 1 each cycle.
  - On the edge where count == SETTLE_CYCLES, ALU_OUT is captured into RES and ALU_ZERO into ZFLAG, and the FSM enters RESP.
- RESP:
  - ACKg = 1 for exactly one cycle, only for the granted requester; the other ACK stays 0.
  - RES/ZFLAG are valid in the ACK cycle and held until the next capture or reset.
- Latency: with REQ sampled at edge N, ALU_* update at N, ACK is high from N+SETTLE_CYCLES to N+SETTLE_CYCLES+1, and IDLE is re-entered at N+SETTLE_CYCLES+1.
  - Throughput is one operation per SETTLE_CYCLES+2 cycles.
- Requester rules:
  - Hold REQ and operands stable until ACK.
  - REQ is sampled only in IDLE; operand changes after grant are ignored.
  - A REQ still high in the IDLE cycle after ACK is treated as a new request.
- Starvation: with both REQ held continuously, grants strictly alternate 0,1,0,1.
- No opcode decoding: ALU_OPRN is passed through verbatim; ALU_* hold their last values in IDLE.
- Reset during EXEC or RESP: the operation is dropped, no ACK is issued, and the requester must re-request.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - Adds output ERR (1 bit, reset 0).
  - At the IDLE grant edge, an opcode outside 1..9 skips EXEC: the FSM goes directly IDLE->RESP, ALU_* are not updated, RES=0, ZFLAG=0, ERR=1 with the ACK.
  - ERR is cleared at the next grant.
  - Valid opcodes behave as normal with ERR=0.
- Undefined: ERR port absent; all opcodes are issued.

Test Plan:
- Reset, then REQ0 with OP1=15, OP2=3, OPRN=0x01, SETTLE=1 -> ALU_OPRN=0x01 one edge after sampling; ACK0 pulses one cycle, 2 cycles after the grant edge; RES=18, ZFLAG=0; ACK1 stays 0.
- REQ1 with 11, 11, OPRN=0x09 (slt) -> RES=0, ZFLAG=1, ACK1 only.
- REQ0 and REQ1 both held with 7*5 and 15-5 -> order ACK0 (RES=35), ACK1 (RES=10), ACK0, ACK1; never the same requester twice in a row.
- SETTLE_CYCLES=4, REQ0 with -1 >> 2 -> ALU_* stable for 4 cycles; RES=0x3FFFFFFF; BUSY high 5 cycles.
- RST pulled low during EXEC -> all outputs 0 immediately; no ACK; a re-issued REQ completes normally.
- With ALU_ARB_OPCHECK_EN, REQ0 with OPRN=0x0F -> ACK0 one edge after grant, ERR=1, RES=0, ALU_* unchanged; the next valid op gives ERR=0.
